// File: rtl/video_pkg.sv
// Shared video definitions: screen geometry, framebuffer address width and
// the pixel/state types used by the pixel write sink.
package video_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned ADDR_W   = 15;

    typedef logic [2:0] colour_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        colour_t           colour;
    } pixel_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        CLEAR_WAIT = 2'd1,
        CLEAR      = 2'd2
    } sink_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with combinational read data; push is ignored when full
// and pop is ignored when empty.
module pixel_fifo #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_din,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_sink.sv
// Buffers range-checked pixel writes, converts (x, y) to a linear address and
// drives the video-memory write port; also performs a full-screen clear sweep.
module pixel_write_sink
    import video_pkg::*;
#(
    parameter int unsigned WIDTH        = SCREEN_W,
    parameter int unsigned HEIGHT       = SCREEN_H,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter colour_t     CLEAR_COLOUR = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [2:0]        colour,
    input  logic              plot,
    output logic              ready,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [7:0]        dropped
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    sink_state_t              r_state;
    sink_state_t              w_state_next;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [2:0]               r_mem_data;
    logic                     r_mem_we;
    logic [7:0]               r_dropped;
    logic [ADDR_W-1:0]        w_addr_next;
    logic [2:0]               w_data_next;
    logic                     w_we_next;
    logic                     w_in_range;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_accept;
    logic                     w_stage_free;
    logic                     w_drained;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    pixel_t                   w_pixel_in;
    pixel_t                   w_pixel_out;

    // Address is formed at enqueue so the output stage only moves data.
    assign w_in_range        = (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
    assign w_pixel_in.addr   = ADDR_W'(32'(y) * 32'(WIDTH) + 32'(x));
    assign w_pixel_in.colour = colour;

    assign busy         = (r_state != RUN);
    assign ready        = !reset && !w_full && !busy;
    assign w_push       = plot && ready && w_in_range;
    assign w_accept     = r_mem_we && mem_ready;
    assign w_stage_free = !r_mem_we || mem_ready;
    assign w_pop        = w_stage_free && !w_empty && (r_state != CLEAR);
    assign w_drained    = (w_count == '0) && w_stage_free;

    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_we   = r_mem_we;
    assign dropped  = r_dropped;

    pixel_fifo #(
        .DATA_W ($bits(pixel_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_pixel_in),
        .i_pop   (w_pop),
        .o_dout  (w_pixel_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Next-state logic for the run / drain-before-clear / sweep sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (clear) w_state_next = CLEAR_WAIT;
                else       w_state_next = RUN;
            end
            CLEAR_WAIT: begin
                if (w_drained) w_state_next = CLEAR;
                else           w_state_next = CLEAR_WAIT;
            end
            CLEAR: begin
                if (w_accept && (r_mem_addr == LAST_ADDR)) w_state_next = RUN;
                else                                       w_state_next = CLEAR;
            end
            default: w_state_next = RUN;
        endcase
    end

    // Output stage: holds while stalled, otherwise reloads from sweep or FIFO.
    always_comb begin
        w_we_next   = r_mem_we;
        w_addr_next = r_mem_addr;
        w_data_next = r_mem_data;
        if (r_state == CLEAR) begin
            if (w_accept) begin
                if (r_mem_addr == LAST_ADDR) begin
                    w_we_next = 1'b0;
                end else begin
                    w_addr_next = r_mem_addr + ADDR_W'(1);
                end
            end else begin
                w_we_next = r_mem_we;
            end
        end else if ((r_state == CLEAR_WAIT) && w_drained) begin
            w_we_next   = 1'b1;
            w_addr_next = '0;
            w_data_next = CLEAR_COLOUR;
        end else if (w_pop) begin
            w_we_next   = 1'b1;
            w_addr_next = w_pixel_out.addr;
            w_data_next = w_pixel_out.colour;
        end else if (w_accept) begin
            w_we_next = 1'b0;
        end else begin
            w_we_next = r_mem_we;
        end
    end

    // State, output register and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= 3'd0;
            r_dropped  <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_mem_we   <= w_we_next;
            r_mem_addr <= w_addr_next;
            r_mem_data <= w_data_next;
            if (plot && ready && !w_in_range && (r_dropped != 8'hFF)) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed self-checking bench for pixel_write_sink.
module tb_pixel_write_sink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  x = 8'd0;
    logic [6:0]  y = 7'd0;
    logic [2:0]  colour = 3'd0;
    logic        plot = 1'b0;
    logic        ready;
    logic        clear = 1'b0;
    logic        busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic [7:0]  dropped;

    int checks = 0;
    int errors = 0;

    logic [14:0] wq_addr[$];
    logic [2:0]  wq_data[$];

    pixel_write_sink dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
        .ready(ready), .clear(clear), .busy(busy), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Write monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && mem_we && mem_ready) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 15'd0)  begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        checks++; if (mem_data !== 3'd0)   begin errors++; $display("FAIL reset_data got %0d want 0", mem_data); end
        checks++; if (dropped !== 8'd0)    begin errors++; $display("FAIL reset_dropped got %0d want 0", dropped); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (ready !== 1'b0)      begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        reset = 1'b0;
        #1;
        checks++; if (ready !== 1'b1)      begin errors++; $display("FAIL post_reset_ready got %b want 1", ready); end
    endtask

    task automatic test_single_pixel();
        clear_log();
        mem_ready = 1'b1;
        x = 8'd3; y = 7'd2; colour = 3'd5; plot = 1'b1;
        tick();
        plot = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_early_we got %b want 0", mem_we); end
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd323 || mem_data !== 3'd5)
            begin errors++; $display("FAIL single_out got we=%b addr=%0d data=%0d want we=1 addr=323 data=5", mem_we, mem_addr, mem_data); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got %b want 0", mem_we); end
        checks++; if (wq_addr.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", wq_addr.size()); end
    endtask

    task automatic test_range();
        clear_log();
        mem_ready = 1'b1;
        plot = 1'b1; colour = 3'd6;
        x = 8'd160; y = 7'd0;   tick();
        x = 8'd0;   y = 7'd120; tick();
        x = 8'd159; y = 7'd119; tick();
        plot = 1'b0;
        tick(); tick(); tick();
        checks++; if (dropped !== 8'd2) begin errors++; $display("FAIL range_dropped got %0d want 2", dropped); end
        checks++; if (wq_addr.size() != 1) begin errors++; $display("FAIL range_writes got %0d want 1", wq_addr.size()); end
        else begin
            checks++; if (wq_addr[0] !== 15'd19199 || wq_data[0] !== 3'd6)
                begin errors++; $display("FAIL range_edge got addr=%0d data=%0d want addr=19199 data=6", wq_addr[0], wq_data[0]); end
        end
        plot = 1'b1; x = 8'd200; y = 7'd5;
        for (int i = 0; i < 300; i++) tick();
        plot = 1'b0;
        tick();
        checks++; if (dropped !== 8'd255) begin errors++; $display("FAIL range_saturate got %0d want 255", dropped); end
        checks++; if (wq_addr.size() != 1) begin errors++; $display("FAIL range_invalid_written got %0d want 1", wq_addr.size()); end
    endtask

    task automatic test_back_pressure();
        int acc;
        int bad;
        logic [14:0] exp_a;
        logic [2:0]  exp_d;
        clear_log();
        mem_ready = 1'b0;
        x = 8'd10; y = 7'd0; colour = 3'd1; plot = 1'b1;
        tick();
        plot = 1'b0;
        tick();
        acc = 0;
        for (int i = 0; i < 17; i++) begin
            logic took;
            x = 8'(20 + i); y = 7'd1; colour = 3'(i); plot = 1'b1;
            took = ready;
            tick();
            if (took) acc++;
        end
        plot = 1'b0;
        checks++; if (acc != 16) begin errors++; $display("FAIL bp_accepts got %0d want 16", acc); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", ready); end
        tick(); tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd10 || mem_data !== 3'd1)
            begin errors++; $display("FAIL bp_hold got we=%b addr=%0d data=%0d want we=1 addr=10 data=1", mem_we, mem_addr, mem_data); end
        mem_ready = 1'b1;
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b want 1", ready); end
        for (int i = 0; i < 30; i++) tick();
        checks++; if (wq_addr.size() != 17) begin errors++; $display("FAIL bp_count got %0d want 17", wq_addr.size()); end
        else begin
            bad = 0;
            for (int i = 0; i < 17; i++) begin
                exp_a = (i == 0) ? 15'd10 : 15'(160 + 20 + i - 1);
                exp_d = (i == 0) ? 3'd1 : 3'(i - 1);
                if (wq_addr[i] !== exp_a || wq_data[i] !== exp_d) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL bp_order got %0d wrong entries want 0", bad); end
        end
    endtask

    task automatic test_clear_order();
        int cyc;
        int busy_bad;
        int bad;
        clear_log();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = 8'(i); y = 7'd3; colour = 3'(i + 1); plot = 1'b1;
            clear = (i == 4);
            tick();
        end
        plot = 1'b0; clear = 1'b0;
        checks++; if (busy !== 1'b1 || ready !== 1'b0)
            begin errors++; $display("FAIL clr_start got busy=%b ready=%b want busy=1 ready=0", busy, ready); end
        cyc = 0; busy_bad = 0;
        while (wq_addr.size() < 19205 && cyc < 40000) begin
            mem_ready = ((cyc % 4) != 3);
            tick();
            cyc++;
            if (wq_addr.size() < 19205 && (busy !== 1'b1 || ready !== 1'b0)) busy_bad++;
        end
        mem_ready = 1'b1;
        checks++; if (cyc >= 40000) begin errors++; $display("FAIL clr_timeout got %0d writes want 19205", wq_addr.size()); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL clr_busy got %0d bad cycles want 0", busy_bad); end
        checks++; if (busy !== 1'b0 || ready !== 1'b1)
            begin errors++; $display("FAIL clr_end got busy=%b ready=%b want busy=0 ready=1", busy, ready); end
        tick(); tick();
        checks++; if (wq_addr.size() != 19205) begin errors++; $display("FAIL clr_count got %0d want 19205", wq_addr.size()); end
        else begin
            bad = 0;
            for (int i = 0; i < 5; i++)
                if (wq_addr[i] !== 15'(480 + i) || wq_data[i] !== 3'(i + 1)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL clr_pixels got %0d wrong want 0", bad); end
            bad = 0;
            for (int k = 0; k < 19200; k++)
                if (wq_addr[5 + k] !== 15'(k) || wq_data[5 + k] !== 3'd0) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL clr_sweep got %0d wrong want 0", bad); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        int snap;
        clear_log();
        mem_ready = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cyc = 0;
        while (!(mem_we === 1'b1 && mem_addr === 15'd5000) && cyc < 6000) begin
            tick();
            cyc++;
        end
        checks++; if (cyc >= 6000) begin errors++; $display("FAIL rmc_reach got addr=%0d want 5000", mem_addr); end
        reset = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_data !== 3'd0 || busy !== 1'b0 || dropped !== 8'd0 || ready !== 1'b0)
            begin errors++; $display("FAIL rmc_reset got we=%b addr=%0d data=%0d busy=%b dropped=%0d ready=%b want all 0", mem_we, mem_addr, mem_data, busy, dropped, ready); end
        reset = 1'b0;
        #1;
        snap = wq_addr.size();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (wq_addr.size() != snap || busy !== 1'b0)
            begin errors++; $display("FAIL rmc_quiet got %0d new writes busy=%b want 0 and 0", wq_addr.size() - snap, busy); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmc_ready got %b want 1", ready); end
        x = 8'd1; y = 7'd1; colour = 3'd6; plot = 1'b1;
        tick();
        plot = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd161 || mem_data !== 3'd6)
            begin errors++; $display("FAIL rmc_plot got we=%b addr=%0d data=%0d want we=1 addr=161 data=6", mem_we, mem_addr, mem_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_range();
        test_back_pressure();
        test_clear_order();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
